fft_band_meter: RTL and testbench
=================================

FFT_BAND_METER -- requirements
Module: fft_band_meter

Interface
REQ-001 Parameter N, 1024: FFT frame length; power of two, 64 to 4096.
REQ-002 Parameter NUM_BANDS, 16: display bands; power of two, at most N/2.
REQ-003 Parameter DATA_W, 65: FFT magnitude word width.
REQ-004 Parameter PWM_W, 8: brightness resolution in bits.
REQ-005 Parameter LEVEL_SHIFT, 24: right shift from band sum to level.
REQ-006 Parameter DECAY, 4: peak-hold decay per frame, in level LSBs.
REQ-007 Port clk  in  1: single clock; the block has no other clock domain.
REQ-008 Port reset  in  1: synchronous, active-high reset.
REQ-009 Port fft_valid  in  1: FFT beat valid.
REQ-010 Port fft_ready  out  1: accept; 1 whenever reset is low, 0 during reset.
REQ-011 Port fft_index  in  $clog2(N): bin index of the beat.
REQ-012 Port fft_data  in  DATA_W: unsigned bin magnitude.
REQ-013 Port mode  in  1: 0 gives a PWM bargraph, 1 gives a threshold display.
REQ-014 Port threshold  in  PWM_W: on-level used in threshold mode.
REQ-015 Port freeze  in  1: holds displayed levels.
REQ-016 Port led  out  NUM_BANDS: per-band LED drive.
REQ-017 Port level  out  NUM_BANDS*PWM_W: held levels, with band k at bits [k*PWM_W +: PWM_W].
REQ-018 Port frame_done  out  1: one-cycle pulse when held levels update.

Function
REQ-019 A beat is accepted when fft_valid & fft_ready; no other beat may change state.
REQ-020 Accepted beats with index >= N/2 shall be ignored for accumulation.
REQ-021 Band b = index / (N/(2*NUM_BANDS)); its accumulator is SUM_W = DATA_W + $clog2(N/(2*NUM_BANDS)) bits and shall never overflow.
REQ-022 On an accepted beat whose offset within its band is 0, the accumulator shall be loaded with fft_data; on any other offset, fft_data shall be added; the update is visible one cycle later.
REQ-023 An accepted beat with index == N-1 commits the frame; frames with missing beats still commit using the current accumulator contents.
REQ-024 On commit, new_level[k] = min(sum[k] >> LEVEL_SHIFT, 2^PWM_W-1), saturating.
REQ-025 Peak hold: if new_level >= held, held <= new_level; otherwise held <= held - DECAY, floored at 0.
REQ-026 Held levels and frame_done shall update on the edge after the commit beat; frame_done shall be high for exactly that one cycle.
REQ-027 While freeze=1, commits shall leave held levels unchanged and frame_done shall still pulse; accumulation continues.
REQ-028 A free-running PWM_W-bit counter shall wrap from 2^PWM_W-1 to 0.
REQ-029 In mode 0, led[k] <= (pwm_cnt < held[k]); held=0 gives always off, and full scale gives off for 1 of 2^PWM_W cycles.
REQ-030 In mode 1, led[k] <= (held[k] >= threshold); the pwm counter is ignored.
REQ-031 led shall be registered, with 1-cycle latency from held/mode/threshold changes.
REQ-032 A mode change mid-frame shall take effect on the next led update, with no glitch beyond that cycle.

Reset
REQ-033 Reset shall clear accumulators, held levels, pwm_cnt, led, and frame_done to 0.
REQ-034 fft_ready shall be 0 during reset.
REQ-035 Reset asserted mid-frame shall discard the partial frame; the next commit follows reset release.

Structure
REQ-036 The shared package fft_view_pkg shall hold the band-index and SUM_W computation functions and the mode encoding constants.
REQ-037 One sub-module, band_peak_hold, shall implement saturation, peak hold and decay for one band; it is instantiated NUM_BANDS times.
REQ-038 Accumulators shall be a single-ported register array indexed by band.

Verification
REQ-039 Directed scenario: N=1024, all bins of band 3 = 2^24 (32 bins), other bins 0, commit -> level[3]=32, others 0, frame_done pulses once.
REQ-040 Directed scenario: one frame with band 0 at level 200, then three all-zero frames -> level[0] = 200, 196, 192, 188.
REQ-041 Directed scenario: a band sum of 2^40 -> level = 255, saturated, with no wrap.
REQ-042 Directed scenario: mode 0 with held=64 -> led high for exactly 64 of 256 cycles; mode 1 with threshold=64 -> on; with threshold=65 -> off.
REQ-043 Directed scenario: freeze=1 across a commit -> levels unchanged and frame_done=1; reset at index 300 then a full frame -> levels reflect only the new frame.
REQ-044 Directed scenario: fft_valid toggled randomly -> sums equal those of a gapless frame.

Source files
------------

// File: rtl/fft_band_meter_pkg.sv
// fft_view_pkg
// Shared definitions for the FFT band meter:
//   - display mode encoding for the 'mode' input
//   - bins_per_band : FFT bins folded into one display band
//   - sum_width     : band accumulator width, wide enough that a full band of
//                     maximum-magnitude bins can never wrap
//   - band_of       : band number that a bin index belongs to
package fft_view_pkg;

  // Display mode encoding
  localparam logic MODE_PWM       = 1'b0;
  localparam logic MODE_THRESHOLD = 1'b1;

  // Only the lower half of the FFT output (positive frequencies) is displayed,
  // so the N/2 useful bins are split evenly over the bands.
  function automatic int bins_per_band(input int n, input int num_bands);
    return n / (2 * num_bands);
  endfunction

  // One extra bit per doubling of bins in a band keeps the sum exact.
  function automatic int sum_width(input int data_w, input int n, input int num_bands);
    return data_w + $clog2(bins_per_band(n, num_bands));
  endfunction

  function automatic int band_of(input int index, input int n, input int num_bands);
    return index / bins_per_band(n, num_bands);
  endfunction

endpackage

// File: rtl/fft_band_meter_if.sv
// fft_band_meter_if
// Beat stream from the FFT core into the band meter.
//   fft_valid : beat valid (driven by master)
//   fft_ready : beat accept (driven by slave)
//   fft_index : bin index of the beat, $clog2(N) bits
//   fft_data  : unsigned bin magnitude, DATA_W bits
interface fft_band_meter_if #(
  parameter int N      = 1024,
  parameter int DATA_W = 65
);

  logic                 fft_valid;
  logic                 fft_ready;
  logic [$clog2(N)-1:0] fft_index;
  logic [DATA_W-1:0]    fft_data;

  modport master (
    output fft_valid,
    output fft_index,
    output fft_data,
    input  fft_ready
  );

  modport slave (
    input  fft_valid,
    input  fft_index,
    input  fft_data,
    output fft_ready
  );

endinterface

// File: rtl/fft_band_meter_band_peak_hold.sv
// band_peak_hold
// Converts one band's accumulated sum to a display level and keeps a
// peak-hold value with linear decay.
//   clk, reset : clock and synchronous active-high reset
//   update     : take a new frame's sum into the held level this cycle
//   sum        : band sum, SUM_W bits
//   held       : held display level, PWM_W bits
module band_peak_hold #(
  parameter int SUM_W       = 70,
  parameter int PWM_W       = 8,
  parameter int LEVEL_SHIFT = 24,
  parameter int DECAY       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             update,
  input  logic [SUM_W-1:0] sum,
  output logic [PWM_W-1:0] held
);

  localparam int LEVEL_MAX = (1 << PWM_W) - 1;

  logic [SUM_W-1:0] shifted;
  logic [PWM_W-1:0] new_level;
  logic [PWM_W-1:0] decayed;

  // Saturate against the full-width shifted sum so large sums clip to full
  // scale instead of wrapping through the narrow level field.
  always_comb begin
    shifted = sum >> LEVEL_SHIFT;
    if (shifted > SUM_W'(LEVEL_MAX)) begin
      new_level = PWM_W'(LEVEL_MAX);
    end else begin
      new_level = shifted[PWM_W-1:0];
    end

    // Decay floors at zero rather than wrapping to a bright level.
    if (int'(held) > DECAY) begin
      decayed = held - PWM_W'(DECAY);
    end else begin
      decayed = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held <= '0;
    end else if (update) begin
      held <= (new_level >= held) ? new_level : decayed;
    end
  end

endmodule

// File: rtl/fft_band_meter.sv
// fft_band_meter
// Folds the lower half of each FFT frame into NUM_BANDS band sums, converts
// them to peak-held levels once per frame and drives one LED per band, either
// as a PWM bargraph or as an on/off threshold display.
//   clk, reset : clock and synchronous active-high reset
//   fft        : beat stream (slave side of fft_band_meter_if)
//   mode       : 0 = PWM bargraph, 1 = threshold display
//   threshold  : on-level for threshold display
//   freeze     : hold displayed levels across frame commits
//   led        : per-band LED drive (registered)
//   level      : held levels, band k at [k*PWM_W +: PWM_W]
//   frame_done : one-cycle pulse when a frame commits
module fft_band_meter
  import fft_view_pkg::*;
#(
  parameter int N           = 1024,
  parameter int NUM_BANDS   = 16,
  parameter int DATA_W      = 65,
  parameter int PWM_W       = 8,
  parameter int LEVEL_SHIFT = 24,
  parameter int DECAY       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  fft_band_meter_if.slave            fft,
  input  logic                       mode,
  input  logic [PWM_W-1:0]           threshold,
  input  logic                       freeze,
  output logic [NUM_BANDS-1:0]       led,
  output logic [NUM_BANDS*PWM_W-1:0] level,
  output logic                       frame_done
);

  localparam int IDX_W  = $clog2(N);
  localparam int BINS   = bins_per_band(N, NUM_BANDS);
  localparam int SUM_W  = sum_width(DATA_W, N, NUM_BANDS);
  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  logic              accept;
  logic              in_lower_half;
  logic              first_of_band;
  logic              commit;
  logic [BAND_W-1:0] beat_band;

  logic [SUM_W-1:0]  acc [NUM_BANDS];
  logic [PWM_W-1:0]  held [NUM_BANDS];
  logic [PWM_W-1:0]  pwm_cnt;
  logic [NUM_BANDS-1:0] led_next;

  assign fft.fft_ready = ~reset;

  // Beat decode. The last bin of the frame lives in the ignored upper half,
  // so committing it never races with an accumulator write.
  always_comb begin
    accept        = fft.fft_valid & fft.fft_ready;
    in_lower_half = fft.fft_index < IDX_W'(N / 2);
    first_of_band = (fft.fft_index & IDX_W'(BINS - 1)) == '0;
    beat_band     = BAND_W'(band_of(int'(fft.fft_index), N, NUM_BANDS));
    commit        = accept & (fft.fft_index == IDX_W'(N - 1));
  end

  // Band accumulators: one write per cycle into the addressed band. The first
  // bin of a band restarts its sum, so no separate frame clear is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        acc[b] <= '0;
      end
    end else if (accept && in_lower_half) begin
      if (first_of_band) begin
        acc[beat_band] <= SUM_W'(fft.fft_data);
      end else begin
        acc[beat_band] <= acc[beat_band] + SUM_W'(fft.fft_data);
      end
    end
  end

  // Per-band level conversion and peak hold. Freeze suppresses the update
  // but the frame still reports completion.
  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
    band_peak_hold #(
      .SUM_W       (SUM_W),
      .PWM_W       (PWM_W),
      .LEVEL_SHIFT (LEVEL_SHIFT),
      .DECAY       (DECAY)
    ) u_hold (
      .clk    (clk),
      .reset  (reset),
      .update (commit & ~freeze),
      .sum    (acc[k]),
      .held   (held[k])
    );

    assign level[k*PWM_W +: PWM_W] = held[k];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit;
    end
  end

  // Free-running brightness counter; wraps naturally at full scale.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // A held level of L lights the LED for L of every 2^PWM_W counter values.
  always_comb begin
    led_next = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      case (mode)
        MODE_PWM:       led_next[k] = pwm_cnt < held[k];
        MODE_THRESHOLD: led_next[k] = held[k] >= threshold;
        default:        led_next[k] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_fft_band_meter.sv
// tb_fft_band_meter
// Self-checking bench for fft_band_meter: a frame-level reference model is
// compared against the DUT outputs every cycle, and directed scenarios pin the
// model with hand-computed levels.
module tb_fft_band_meter;

  localparam int N           = 1024;
  localparam int NUM_BANDS   = 16;
  localparam int DATA_W      = 65;
  localparam int PWM_W       = 8;
  localparam int LEVEL_SHIFT = 24;
  localparam int DECAY       = 4;
  localparam int IDX_W       = $clog2(N);
  localparam int BINS        = N / (2 * NUM_BANDS);
  localparam int LW          = NUM_BANDS * PWM_W;
  localparam int LMAX        = (1 << PWM_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mode;
  logic [PWM_W-1:0]     threshold;
  logic                 freeze;
  logic [NUM_BANDS-1:0] led;
  logic [LW-1:0]        level;
  logic                 frame_done;

  fft_band_meter_if #(.N(N), .DATA_W(DATA_W)) fft_bus ();

  fft_band_meter #(
    .N           (N),
    .NUM_BANDS   (NUM_BANDS),
    .DATA_W      (DATA_W),
    .PWM_W       (PWM_W),
    .LEVEL_SHIFT (LEVEL_SHIFT),
    .DECAY       (DECAY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fft        (fft_bus),
    .mode       (mode),
    .threshold  (threshold),
    .freeze     (freeze),
    .led        (led),
    .level      (level),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [127:0]         m_sum [NUM_BANDS];
  int                   m_held [NUM_BANDS];
  int                   m_pwm;
  logic [NUM_BANDS-1:0] m_led;
  logic                 m_fd;

  logic [DATA_W-1:0]    frame_bins [N];
  bit                   check_en = 1'b0;
  int                   n_checks = 0;
  int                   n_pass = 0;
  int                   fd_count = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int level_of(input logic [127:0] s);
    logic [127:0] sh;
    sh = s >> LEVEL_SHIFT;
    if (sh > 128'(LMAX)) return LMAX;
    return int'(sh);
  endfunction

  function automatic logic [LW-1:0] one_band(input int band, input int value);
    return LW'(value) << (band * PWM_W);
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom_range(0, 32'h03FF_FFFF));
    d = d >> $urandom_range(0, 4);
    if ($urandom_range(0, 31) == 0) d = DATA_W'({$urandom, $urandom, $urandom});
    return d;
  endfunction

  // Frame-level model: bins fold into bands, bin N-1 commits every band.
  initial begin : model
    int idx;
    int nl;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          m_sum[b]  = '0;
          m_held[b] = 0;
        end
        m_pwm = 0;
        m_led = '0;
        m_fd  = 1'b0;
      end else begin
        for (int k = 0; k < NUM_BANDS; k++) begin
          m_led[k] = mode ? (m_held[k] >= int'(threshold)) : (m_pwm < m_held[k]);
        end
        m_fd = 1'b0;
        if (fft_bus.fft_valid) begin
          idx = int'(fft_bus.fft_index);
          if (idx == N - 1) begin
            m_fd = 1'b1;
            if (!freeze) begin
              for (int k = 0; k < NUM_BANDS; k++) begin
                nl = level_of(m_sum[k]);
                if (nl >= m_held[k]) m_held[k] = nl;
                else m_held[k] = (m_held[k] > DECAY) ? m_held[k] - DECAY : 0;
              end
            end
          end
          if (idx < N / 2) begin
            if (idx % BINS == 0) m_sum[idx / BINS] = 128'(fft_bus.fft_data);
            else m_sum[idx / BINS] = m_sum[idx / BINS] + 128'(fft_bus.fft_data);
          end
        end
        m_pwm = (m_pwm + 1) % (LMAX + 1);
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial begin : compare
    logic [LW-1:0] exp_level;
    forever begin
      @(negedge clk);
      if (check_en) begin
        for (int k = 0; k < NUM_BANDS; k++) exp_level[k*PWM_W +: PWM_W] = PWM_W'(m_held[k]);
        checkOutput("level", 256'(level), 256'(exp_level));
        checkOutput("led", 256'(led), 256'(m_led));
        checkOutput("frame_done", 256'(frame_done), 256'(m_fd));
        checkOutput("fft_ready", 256'(fft_bus.fft_ready), 256'(!reset));
        if (frame_done === 1'b1) fd_count++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    fft_bus.fft_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clearFrame();
    for (int i = 0; i < N; i++) frame_bins[i] = '0;
  endtask

  // Sends bins 0..last_index in order; idle cycles carry junk index/data.
  task automatic applyStimulus(input int valid_pct, input int last_index);
    int i;
    i = 0;
    while (i <= last_index) begin
      @(posedge clk);
      #1;
      if (int'($urandom_range(1, 100)) <= valid_pct) begin
        fft_bus.fft_valid = 1'b1;
        fft_bus.fft_index = IDX_W'(i);
        fft_bus.fft_data  = frame_bins[i];
        i++;
      end else begin
        fft_bus.fft_valid = 1'b0;
        fft_bus.fft_index = IDX_W'($urandom);
        fft_bus.fft_data  = DATA_W'({$urandom, $urandom, $urandom});
      end
    end
    @(posedge clk);
    #1;
    fft_bus.fft_valid = 1'b0;
  endtask

  initial begin : main
    int cnt;
    logic [127:0] s;
    logic [LW-1:0] exp_vec;

    reset = 1'b1;
    mode = 1'b0;
    threshold = '0;
    freeze = 1'b0;
    fft_bus.fft_valid = 1'b0;
    fft_bus.fft_index = '0;
    fft_bus.fft_data  = '0;

    // Reset state
    idle(2);
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", 256'(fft_bus.fft_ready), 256'(0));
    checkOutput("reset_level", 256'(level), 256'(0));
    checkOutput("reset_led", 256'(led), 256'(0));
    checkOutput("reset_frame_done", 256'(frame_done), 256'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Band 3 fully at 2^24 per bin -> level 32
    clearFrame();
    for (int i = 3 * BINS; i < 4 * BINS; i++) frame_bins[i] = DATA_W'(1) << 24;
    fd_count = 0;
    applyStimulus(100, N - 1);
    idle(3);
    checkOutput("band3_level", 256'(level), 256'(one_band(3, 32)));
    checkOutput("band3_done_pulses", 256'(fd_count), 256'(1));

    // Peak hold decay: 200 then three empty frames
    doReset(2);
    clearFrame();
    frame_bins[0] = DATA_W'(200) << 24;
    applyStimulus(100, N - 1);
    idle(2);
    checkOutput("decay_0", 256'(level), 256'(one_band(0, 200)));
    clearFrame();
    applyStimulus(100, N - 1);
    idle(2);
    checkOutput("decay_1", 256'(level), 256'(one_band(0, 196)));
    applyStimulus(100, N - 1);
    idle(2);
    checkOutput("decay_2", 256'(level), 256'(one_band(0, 192)));
    applyStimulus(100, N - 1);
    idle(2);
    checkOutput("decay_3", 256'(level), 256'(one_band(0, 188)));

    // Saturation: 2^40 in band 5; band 6 full of maximum magnitudes
    doReset(2);
    clearFrame();
    frame_bins[5 * BINS] = DATA_W'(1) << 40;
    for (int i = 6 * BINS; i < 7 * BINS; i++) frame_bins[i] = '1;
    applyStimulus(100, N - 1);
    idle(2);
    checkOutput("saturate", 256'(level), 256'(one_band(5, 255) | one_band(6, 255)));

    // PWM duty and threshold display with held = 64 in band 2
    doReset(2);
    clearFrame();
    frame_bins[2 * BINS] = DATA_W'(64) << 24;
    applyStimulus(100, N - 1);
    mode = 1'b0;
    idle(2);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (led[2]) cnt++;
    end
    checkOutput("pwm_duty_64", 256'(cnt), 256'(64));
    @(posedge clk);
    #1;
    mode = 1'b1;
    threshold = 8'd64;
    idle(2);
    @(negedge clk);
    checkOutput("thresh_64_on", 256'(led), 256'(16'h0004));
    @(posedge clk);
    #1;
    threshold = 8'd65;
    idle(2);
    @(negedge clk);
    checkOutput("thresh_65_off", 256'(led), 256'(0));

    // Freeze across a commit
    freeze = 1'b1;
    fd_count = 0;
    frame_bins[2 * BINS] = DATA_W'(100) << 24;
    applyStimulus(100, N - 1);
    idle(2);
    checkOutput("freeze_level", 256'(level), 256'(one_band(2, 64)));
    checkOutput("freeze_done", 256'(fd_count), 256'(1));
    freeze = 1'b0;

    // Reset at index 300 discards the partial frame
    clearFrame();
    for (int i = 9 * BINS; i < 10 * BINS; i++) frame_bins[i] = DATA_W'(77) << 24;
    applyStimulus(100, 300);
    doReset(3);
    clearFrame();
    frame_bins[7 * BINS + 5] = DATA_W'(50) << 24;
    applyStimulus(100, N - 1);
    idle(2);
    checkOutput("reset_midframe", 256'(level), 256'(one_band(7, 50)));

    // Gappy valid gives the same levels as a gapless frame
    for (int i = 0; i < N; i++) frame_bins[i] = rand_data();
    for (int b = 0; b < NUM_BANDS; b++) begin
      s = '0;
      for (int i = b * BINS; i < (b + 1) * BINS; i++) s = s + 128'(frame_bins[i]);
      exp_vec[b*PWM_W +: PWM_W] = PWM_W'(level_of(s));
    end
    doReset(2);
    applyStimulus(50, N - 1);
    idle(2);
    checkOutput("gappy_levels", 256'(level), 256'(exp_vec));
    doReset(2);
    applyStimulus(100, N - 1);
    idle(2);
    checkOutput("gapless_levels", 256'(level), 256'(exp_vec));

    // Random frames with random display settings, checked by the model
    repeat (6) begin
      mode = 1'($urandom_range(0, 1));
      threshold = PWM_W'($urandom);
      freeze = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) frame_bins[i] = rand_data();
      for (int b = 0; b < NUM_BANDS; b++) begin
        if ($urandom_range(0, 2) == 0) begin
          for (int i = b * BINS; i < (b + 1) * BINS; i++) frame_bins[i] = '0;
        end
      end
      applyStimulus(int'($urandom_range(40, 100)), N - 1);
      idle(int'($urandom_range(1, 20)));
    end

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
